status_tx: RTL and testbench

STATUS_TX -- requirements
Module: status_tx

---
 rtl/enum_type.sv | 20 ++
 rtl/bin_to_dec.sv | 49 ++++
 rtl/status_tx.sv | 101 ++++++++++
 tb/tb_status_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enum_type.sv
// enum_type: FSM states, message kinds, ASCII constants and digit helpers shared by status_tx.
package enum_type;
  typedef enum logic [2:0] {IDLE, CONVERT, LOAD, SEND, WAIT_BUSY, WAIT_DONE} tx_state_type;
  typedef enum logic [1:0] {MSG_OVER, MSG_START, MSG_TIME} msg_kind_type;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [3:0] LEN_OVER = 4'd12;
  localparam logic [3:0] LEN_START = 4'd7;
  localparam logic [3:0] LEN_TIME = 4'd6;
  localparam logic [6:0] CD_MAX = 7'd99;
  localparam logic [2:0] RETRY_LAST = 3'd7;
  function automatic logic [15:0] dec_weight(input logic [2:0] pos);
    return pos == 3'd0 ? 16'd10000 : pos == 3'd1 ? 16'd1000 : pos == 3'd2 ? 16'd100 :
           pos == 3'd3 ? 16'd10 : 16'd1;
  endfunction
  function automatic logic [7:0] ascii(input logic [3:0] d);
    return ZERO + {4'd0, d};
  endfunction
endpackage

// File: rtl/bin_to_dec.sv
// bin_to_dec: 16-bit binary to five BCD digits by repeated subtraction, start/done handshake.
module bin_to_dec
  import enum_type::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] digits,
  output logic        done
);
  logic [15:0] rem;
  logic [15:0] w;
  logic [2:0]  pos;
  logic [3:0]  cnt;
  logic        run;
  assign w = dec_weight(pos);
  // One subtraction or one digit store per cycle: at most 45 + 5 cycles.
  always_ff @(posedge clk)
    if (!reset_n) begin
      run <= 1'b0;
      done <= 1'b0;
      rem <= 16'd0;
      pos <= 3'd0;
      cnt <= 4'd0;
      digits <= 20'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        rem <= bin;
        pos <= 3'd0;
        cnt <= 4'd0;
      end else if (run) begin
        if (rem >= w) begin
          rem <= rem - w;
          cnt <= cnt + 4'd1;
        end else begin
          digits[{3'd4 - pos, 2'b00} +: 4] <= cnt;
          cnt <= 4'd0;
          pos <= pos + 3'd1;
          if (pos == 3'd4) begin
            run <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
endmodule

// File: rtl/status_tx.sv
// status_tx: turns game START/OVER/second events into ASCII status lines sent byte by byte to a uart.
module status_tx
  import enum_type::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        over,
  input  logic        sec_tick,
  input  logic [6:0]  count_down,
  input  logic [15:0] score,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy
);
  tx_state_type state, state_n;
  msg_kind_type kind;
  logic        start_q, over_q, p_over, p_start, p_time;
  logic        pick, sel_over, sel_start, sel_time, conv_done;
  logic [6:0]  cd_lat;
  logic [3:0]  idx, idx_inc, len;
  logic [2:0]  wd;
  logic [7:0]  byte_q;
  logic [7:0]  msg [12];
  logic [95:0] img;
  logic [19:0] digits;
  logic [15:0] conv_in;
  assign pick = state == IDLE && (p_over || p_start || p_time) && !is_transmitting;
  assign sel_over = pick && p_over;
  assign sel_start = pick && !p_over && p_start;
  assign sel_time = pick && !p_over && !p_start;
  assign conv_in = p_over ? score : {9'd0, cd_lat};
  assign idx_inc = idx + 4'd1;
  assign busy = state != IDLE;
  assign transmit = state == SEND;
  assign tx_byte = transmit ? msg[idx] : byte_q;
  // The converter captures its operand on pick, which is also when score is latched.
  bin_to_dec u_conv (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (pick),
    .bin    (conv_in),
    .digits (digits),
    .done   (conv_done)
  );
  always_comb
    img = kind == MSG_OVER ? {"OVER ", ascii(digits[19:16]), ascii(digits[15:12]), ascii(digits[11:8]),
                              ascii(digits[7:4]), ascii(digits[3:0]), CR, LF} :
          kind == MSG_START ? {"START", CR, LF, 40'd0} :
          {"T=", ascii(digits[7:4]), ascii(digits[3:0]), CR, LF, 48'd0};
  always_ff @(posedge clk)
    if (state == LOAD)
      for (int i = 0; i < 12; i++) msg[i] <= img[8*(11-i) +: 8];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = pick ? CONVERT : IDLE;
      CONVERT:   state_n = conv_done ? LOAD : CONVERT;
      LOAD:      state_n = SEND;
      SEND:      state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = is_transmitting ? WAIT_DONE : wd == RETRY_LAST ? SEND : WAIT_BUSY;
      WAIT_DONE: state_n = is_transmitting ? WAIT_DONE : idx_inc == len ? IDLE : SEND;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      start_q <= 1'b0;
      over_q <= 1'b0;
      p_over <= 1'b0;
      p_start <= 1'b0;
      p_time <= 1'b0;
      cd_lat <= 7'd0;
      kind <= MSG_TIME;
      len <= 4'd0;
      idx <= 4'd0;
      wd <= 3'd0;
      byte_q <= 8'd0;
    end else begin
      state <= state_n;
      start_q <= start;
      over_q <= over;
      p_over <= (over && !over_q) || (p_over && !sel_over);
      p_start <= (start && !start_q) || (p_start && !sel_start);
      p_time <= sec_tick || (p_time && !sel_time);
      if (sec_tick) cd_lat <= count_down > CD_MAX ? CD_MAX : count_down;
      if (pick) kind <= sel_over ? MSG_OVER : sel_start ? MSG_START : MSG_TIME;
      if (state == LOAD) begin
        len <= kind == MSG_OVER ? LEN_OVER : kind == MSG_START ? LEN_START : LEN_TIME;
        idx <= 4'd0;
      end
      if (state == SEND) begin
        byte_q <= msg[idx];
        wd <= 3'd0;
      end
      if (state == WAIT_BUSY && !is_transmitting) wd <= wd + 3'd1;
      if (state == WAIT_DONE && !is_transmitting) idx <= idx_inc;
    end
endmodule

// File: tb/tb_status_tx.sv
// tb_status_tx: randomized scenarios against a message-level model of status_tx with a busy-for-20-cycles uart.
module tb_status_tx;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        over = 1'b0;
  logic        sec_tick = 1'b0;
  logic [6:0]  count_down = 7'd0;
  logic [15:0] score = 16'd0;
  logic        is_transmitting;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];
  int          st [$];
  int          cyc = 0, bcnt = 0, dbl = 0, ignore_at = -1, base = 0;
  int          total = 0, bad = 0;
  logic        prev_tx = 1'b0;

  status_tx dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .over           (over),
    .sec_tick       (sec_tick),
    .count_down     (count_down),
    .score          (score),
    .is_transmitting(is_transmitting),
    .transmit       (transmit),
    .tx_byte        (tx_byte),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart model: every strobe is logged; an accepted strobe keeps the line busy for 20 cycles
  assign is_transmitting = bcnt != 0;
  always @(negedge clk) begin
    prev_tx <= transmit;
    if (transmit && prev_tx) dbl <= dbl + 1;
    if (transmit) begin
      if (got.size() != ignore_at) bcnt <= 20;
      got.push_back(tx_byte);
      st.push_back(cyc);
    end else if (bcnt > 0) bcnt <= bcnt - 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  function automatic void expect_msg(input int kind, input int val);
    string s;
    if (kind == 0) s = $sformatf("OVER %05d%c%c", val, 13, 10);
    else if (kind == 1) s = $sformatf("START%c%c", 13, 10);
    else s = $sformatf("T=%02d%c%c", val > 99 ? 99 : val, 13, 10);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < got.size() - base || i < exp_q.size(); i++)
      if (i >= got.size() - base || i >= exp_q.size() || got[base+i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return i < got.size() - base ? got[base+i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return i < exp_q.size() ? exp_q[i] : 8'hxx;
  endfunction

  task automatic begin_msg();
    base = got.size();
    exp_q.delete();
  endtask

  task automatic run_events(input bit ev_over, input bit ev_start, input bit ev_tick, input int sc, input int cd);
    @(negedge clk);
    start = 1'b0;
    over = 1'b0;
    score = 16'(sc);
    @(negedge clk);
    over = ev_over;
    start = ev_start;
    sec_tick = ev_tick;
    count_down = 7'(cd);
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int q = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      q = (!busy && !is_transmitting) ? q + 1 : 0;
      if (q >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (got.size() >= base + n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (transmit !== 1'b0) begin bad++; $display("FAIL reset_transmit got=%b want=0", transmit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte got=%h want=00", tx_byte); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start();
    bit ok; int d, dbl0;
    dbl0 = dbl;
    begin_msg();
    expect_msg(1, 0);
    run_events(0, 1, 0, 0, 0);
    wait_quiet(2000, ok);
    d = first_diff();
    total++; if (!ok) begin bad++; $display("FAIL start_timeout got=busy want=idle"); end
    total++; if (d != -1) begin bad++; $display("FAIL start_bytes at %0d got=%h want=%h", d, got_at(d), exp_at(d)); end
    total++; if (dbl != dbl0) begin bad++; $display("FAIL start_strobe_width got=%0d want=%0d", dbl, dbl0); end
  endtask

  task automatic test_over();
    bit ok; int d;
    begin_msg();
    expect_msg(0, 1234);
    run_events(1, 0, 0, 1234, 0);
    wait_quiet(3000, ok);
    d = first_diff();
    total++; if (!ok) begin bad++; $display("FAIL over_timeout got=busy want=idle"); end
    total++; if (d != -1) begin bad++; $display("FAIL over_bytes at %0d got=%h want=%h", d, got_at(d), exp_at(d)); end
    total++; if (tx_byte !== 8'h0A) begin bad++; $display("FAIL over_tx_byte_hold got=%h want=0a", tx_byte); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bit ok; int d, m, sc, cd;
      m = $urandom_range(1, 7);
      sc = it == 0 ? 0 : it == 1 ? 65535 : $urandom_range(0, 65535);
      cd = $urandom_range(0, 127);
      begin_msg();
      if (m[0]) expect_msg(0, sc);
      if (m[1]) expect_msg(1, 0);
      if (m[2]) expect_msg(2, cd);
      run_events(m[0], m[1], m[2], sc, cd);
      wait_quiet(8000, ok);
      d = first_diff();
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout got=busy want=idle", it); end
      total++; if (d != -1) begin bad++; $display("FAIL rand%0d_bytes mask=%0d at %0d got=%h want=%h", it, m, d, got_at(d), exp_at(d)); end
    end
  endtask

  task automatic test_simultaneous();
    bit ok; int d;
    begin_msg();
    expect_msg(0, 4321);
    expect_msg(1, 0);
    expect_msg(2, 7);
    run_events(1, 1, 1, 4321, 7);
    wait_quiet(8000, ok);
    d = first_diff();
    total++; if (!ok) begin bad++; $display("FAIL simul_timeout got=busy want=idle"); end
    total++; if (d != -1) begin bad++; $display("FAIL simul_bytes at %0d got=%h want=%h", d, got_at(d), exp_at(d)); end
  endtask

  task automatic test_coalesce();
    bit ok, ok2; int d;
    begin_msg();
    expect_msg(0, 808);
    expect_msg(2, 57);
    run_events(1, 0, 0, 808, 0);
    wait_bytes(2, 500, ok);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sec_tick = 1'b1;
      count_down = 7'(59 - k);
      @(negedge clk);
      sec_tick = 1'b0;
      repeat (5) @(negedge clk);
    end
    wait_quiet(6000, ok2);
    d = first_diff();
    total++; if (!ok) begin bad++; $display("FAIL coalesce_start got=%0d want=2 bytes", got.size() - base); end
    total++; if (!ok2) begin bad++; $display("FAIL coalesce_timeout got=busy want=idle"); end
    total++; if (d != -1) begin bad++; $display("FAIL coalesce_bytes at %0d got=%h want=%h", d, got_at(d), exp_at(d)); end
  endtask

  task automatic test_saturation();
    int cds [3] = '{120, 99, 0};
    foreach (cds[k]) begin
      bit ok; int d;
      begin_msg();
      expect_msg(2, cds[k]);
      run_events(0, 0, 1, 0, cds[k]);
      wait_quiet(2000, ok);
      d = first_diff();
      total++; if (!ok) begin bad++; $display("FAIL sat%0d_timeout got=busy want=idle", cds[k]); end
      total++; if (d != -1) begin bad++; $display("FAIL sat%0d_bytes at %0d got=%h want=%h", cds[k], d, got_at(d), exp_at(d)); end
    end
  endtask

  task automatic test_lost_strobe();
    bit ok; int d, gap;
    begin_msg();
    exp_q.push_back(8'h53);
    expect_msg(1, 0);
    ignore_at = got.size();
    run_events(0, 1, 0, 0, 0);
    wait_quiet(2000, ok);
    ignore_at = -1;
    d = first_diff();
    gap = got.size() >= base + 2 ? st[base+1] - st[base] : -1;
    total++; if (!ok) begin bad++; $display("FAIL lost_timeout got=busy want=idle"); end
    total++; if (d != -1) begin bad++; $display("FAIL lost_bytes at %0d got=%h want=%h", d, got_at(d), exp_at(d)); end
    total++; if (gap < 8 || gap > 9) begin bad++; $display("FAIL lost_regap got=%0d want=8..9 cycles", gap); end
  endtask

  task automatic test_reset_mid();
    bit ok; int d;
    begin_msg();
    exp_q = '{8'h4F, 8'h56, 8'h45, 8'h52};
    run_events(1, 0, 0, 31337, 0);
    wait_bytes(4, 500, ok);
    @(negedge clk);
    reset_n = 1'b0;
    over = 1'b0;
    @(negedge clk);
    total++; if (transmit !== 1'b0) begin bad++; $display("FAIL rstmid_transmit got=%b want=0", transmit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    d = first_diff();
    total++; if (!ok) begin bad++; $display("FAIL rstmid_reach got=%0d want=4 bytes", got.size() - base); end
    total++; if (d != -1) begin bad++; $display("FAIL rstmid_bytes at %0d got=%h want=%h", d, got_at(d), exp_at(d)); end
  endtask

  task automatic test_start_at_release();
    bit ok; int d;
    begin_msg();
    expect_msg(1, 0);
    @(negedge clk);
    reset_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_quiet(2000, ok);
    d = first_diff();
    total++; if (!ok) begin bad++; $display("FAIL release_timeout got=busy want=idle"); end
    total++; if (d != -1) begin bad++; $display("FAIL release_bytes at %0d got=%h want=%h", d, got_at(d), exp_at(d)); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_over();
    test_random();
    test_simultaneous();
    test_coalesce();
    test_saturation();
    test_lost_strobe();
    test_reset_mid();
    test_start_at_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
